// File: rtl/instr_encoder_pkg.sv
// Shared opcode, mode and condition constants for the instruction encoder,
// plus helpers for legality, S-bit forcing and field re-decode.
package instr_encoder_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RET = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_LDR = 4'b0100;
    localparam logic [3:0] OP_B   = 4'b1001;
    localparam logic [3:0] OP_BL  = 4'b1011;

    localparam logic [3:0]  COND_AL   = 4'hE;
    localparam logic [31:0] TERM_WORD = {COND_AL, 3'b101, 1'b0, 24'hFFFFFE};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_TERM,
        ST_DONE
    } enc_state_e;

    function automatic logic is_legal(input logic [1:0] mode, input logic [3:0] opc);
        case (mode)
            MODE_DP:  return opc inside {OP_MOV, OP_MVN, OP_ADD, OP_ADC, OP_SUB, OP_SBC,
                                         OP_AND, OP_ORR, OP_EOR, OP_CMP, OP_TST, OP_RET};
            MODE_MEM: return opc == OP_LDR;
            MODE_BR:  return (opc == OP_B) || (opc == OP_BL);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic force_s(input logic [1:0] mode, input logic [3:0] opc,
                                     input logic s);
        if (mode == MODE_DP && (opc == OP_CMP || opc == OP_TST)) return 1'b1;
        if (mode == MODE_DP && opc == OP_RET) return 1'b0;
        return s;
    endfunction

    // Recovers {mode, opCode, S} from word bits [27:20]; branches carry S=0.
    function automatic logic [6:0] redecode(input logic [7:0] f);
        if (f[7:5] == 3'b101) return {MODE_BR, (f[4] ? OP_BL : OP_B), 1'b0};
        return {f[7:6], f[4:1], f[0]};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request channel and instruction-memory write channel of the encoder.
// master = encoder side, slave = request source / memory side.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_cond;
    logic [1:0]        req_mode;
    logic [3:0]        req_opCode;
    logic              req_S;
    logic              req_I;
    logic [3:0]        req_rn;
    logic [3:0]        req_rd;
    logic [11:0]       req_op2;
    logic [23:0]       req_imm24;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ack;

    modport master (
        input  req_valid, req_cond, req_mode, req_opCode, req_S, req_I,
               req_rn, req_rd, req_op2, req_imm24, imem_ack,
        output req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output req_valid, req_cond, req_mode, req_opCode, req_S, req_I,
               req_rn, req_rd, req_op2, req_imm24, imem_ack,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_fifo.sv
// instr_enc_fifo: DEPTH x WIDTH synchronous FIFO with occupancy count.
// Push while full and pop while empty are dropped.
module instr_enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic instruction requests, queues them and
// writes them to imem, then a branch-to-self on seal. Option: INSTR_ENC_SELFCHECK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    instr_encoder_if.master   bus,
    input  logic              seal,
    output logic              err,
    output logic              done
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

`ifdef INSTR_ENC_SELFCHECK_EN
    localparam int unsigned FW = 39;
`else
    localparam int unsigned FW = 32;
`endif

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic          enc_legal, enc_s, accept, push, pop, last;
    logic [31:0]   enc_word, head_word;
    logic          fifo_full, fifo_empty, chk_fail;
    logic [CW-1:0] fifo_count;
    logic [FW-1:0] fifo_din, fifo_dout;
    logic          we;
    logic [31:0]   wdata;

    always_comb begin
        enc_legal = is_legal(bus.req_mode, bus.req_opCode);
        enc_s     = force_s(bus.req_mode, bus.req_opCode, bus.req_S);
        if (bus.req_mode == MODE_BR)
            enc_word = {bus.req_cond, 3'b101, (bus.req_opCode == OP_BL), bus.req_imm24};
        else
            enc_word = {bus.req_cond, bus.req_mode, bus.req_I, bus.req_opCode, enc_s,
                        bus.req_rn, bus.req_rd, bus.req_op2};
    end

    assign bus.req_ready = !fifo_full && (state_q != ST_DONE) && (state_q != ST_TERM);
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = accept && enc_legal;
    assign last          = (fifo_count == CW'(1));

`ifdef INSTR_ENC_SELFCHECK_EN
    // The expected fields ride in the FIFO beside the word they describe.
    assign fifo_din  = {bus.req_mode, bus.req_opCode,
                        ((bus.req_mode == MODE_BR) ? 1'b0 : enc_s), enc_word};
    assign head_word = fifo_dout[31:0];
    assign chk_fail  = (state_q == ST_WRITE) &&
                       (redecode(fifo_dout[27:20]) != fifo_dout[38:32]);
`else
    assign fifo_din  = enc_word;
    assign head_word = fifo_dout;
    assign chk_fail  = 1'b0;
`endif

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q | (accept && !enc_legal);
        pop     = 1'b0;
        we      = 1'b0;
        wdata   = '0;
        case (state_q)
            ST_IDLE: begin
                if (seal && fifo_empty && !push) state_d = ST_TERM;
                else if (!fifo_empty)            state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (chk_fail) begin
                    pop   = 1'b1;
                    err_d = 1'b1;
                    if (last && !push) state_d = ST_IDLE;
                end else begin
                    we    = 1'b1;
                    wdata = head_word;
                    if (bus.imem_ack) begin
                        pop    = 1'b1;
                        addr_d = addr_q + ADDR_W'(4);
                        if (last && !push) state_d = ST_IDLE;
                    end
                end
            end
            ST_TERM: begin
                we    = 1'b1;
                wdata = TERM_WORD;
                if (bus.imem_ack) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    state_d = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign bus.imem_we    = we;
    assign bus.imem_wdata = wdata;
    assign bus.imem_addr  = addr_q;
    assign err            = err_q;
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a word-level model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BOUND = 300;

    typedef struct {
        logic [3:0]  cond;
        logic [1:0]  mode;
        logic [3:0]  opc;
        logic        s;
        logic        i;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] op2;
        logic [23:0] imm24;
    } req_s;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic seal = 1'b0;
    logic err, done;
    int   vectors = 0;
    int   miscompares = 0;

    instr_encoder_if #(.ADDR_W(32)) bus ();

    instr_encoder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (32),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .seal (seal),
        .err  (err),
        .done (done)
    );

    always #5 clk = ~clk;

    // Reference: bit 32 = legal, [31:0] = word, built field by field from the format rules.
    function automatic logic [32:0] ref_encode(input req_s r);
        logic        legal;
        logic        sbit;
        logic [31:0] w;
        case (r.mode)
            2'd0: legal = r.opc inside {OP_MOV, OP_MVN, OP_ADD, OP_ADC, OP_SUB, OP_SBC,
                                        OP_AND, OP_ORR, OP_EOR, OP_CMP, OP_TST, OP_RET};
            2'd1: legal = (r.opc == OP_LDR);
            2'd2: legal = (r.opc == OP_B) || (r.opc == OP_BL);
            default: legal = 1'b0;
        endcase
        if (r.mode == 2'd2) begin
            w = (32'(r.cond) << 28) | (32'd5 << 25) | (32'(r.opc == OP_BL) << 24) | 32'(r.imm24);
        end else begin
            sbit = r.s;
            if (r.mode == 2'd0 && (r.opc == OP_CMP || r.opc == OP_TST)) sbit = 1'b1;
            if (r.mode == 2'd0 && r.opc == OP_RET) sbit = 1'b0;
            w = (32'(r.cond) << 28) | (32'(r.mode) << 26) | (32'(r.i) << 25) |
                (32'(r.opc) << 21) | (32'(sbit) << 20) | (32'(r.rn) << 16) |
                (32'(r.rd) << 12) | 32'(r.op2);
        end
        return {legal, w};
    endfunction

    function automatic req_s rand_req();
        req_s r;
        logic [3:0] dp_ops [12] = '{OP_MOV, OP_MVN, OP_ADD, OP_ADC, OP_SUB, OP_SBC,
                                    OP_AND, OP_ORR, OP_EOR, OP_CMP, OP_TST, OP_RET};
        r.cond  = 4'($urandom);
        r.s     = 1'($urandom);
        r.i     = 1'($urandom);
        r.rn    = 4'($urandom);
        r.rd    = 4'($urandom);
        r.op2   = 12'($urandom);
        r.imm24 = 24'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin r.mode = 2'd0; r.opc = dp_ops[$urandom_range(0, 11)]; end
            4, 5:       begin r.mode = 2'd1; r.opc = OP_LDR; end
            6, 7:       begin r.mode = 2'd2; r.opc = ($urandom_range(0, 1) != 0) ? OP_BL : OP_B; end
            default:    begin r.mode = 2'($urandom); r.opc = 4'($urandom); end
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seal = 1'b0;
        bus.req_valid = 1'b0;
        bus.imem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send(input req_s r, output bit ok);
        bus.req_cond = r.cond;   bus.req_mode = r.mode;  bus.req_opCode = r.opc;
        bus.req_S = r.s;         bus.req_I = r.i;        bus.req_rn = r.rn;
        bus.req_rd = r.rd;       bus.req_op2 = r.op2;    bus.req_imm24 = r.imm24;
        bus.req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_we(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (bus.imem_we) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic pulse_ack();
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (bus.imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", bus.imem_we); end
        if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
        if (bus.imem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", bus.imem_wdata); end
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_single(input string name, input req_s r, input logic [31:0] want);
        bit ok;
        logic [32:0] m;
        do_reset();
        m = ref_encode(r);
        send(r, ok);
        wait_we(ok);
        vectors += 5;
        if (!ok) begin miscompares++; $display("FAIL %s_we_timeout got 0 want 1", name); end
        if (bus.imem_wdata !== want) begin miscompares++; $display("FAIL %s_word got %h want %h", name, bus.imem_wdata, want); end
        if (m[31:0] !== want) begin miscompares++; $display("FAIL %s_model got %h want %h", name, m[31:0], want); end
        if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL %s_addr got %h want 0", name, bus.imem_addr); end
        pulse_ack();
        if (bus.imem_addr !== 32'h4 || bus.imem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_after_ack got addr=%h we=%b want addr=4 we=0", name, bus.imem_addr, bus.imem_we);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        bit saw_we;
        req_s r;
        do_reset();
        r = rand_req();
        r.mode = 2'b11;
        send(r, ok);
        vectors += 3;
        if (!ok) begin miscompares++; $display("FAIL illegal_accept got 0 want 1"); end
        if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_err got %b want 1", err); end
        saw_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_we) saw_we = 1'b1;
            step();
        end
        if (saw_we || err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_sticky got we_seen=%b err=%b want 0/1", saw_we, err);
        end
    endtask

    task automatic test_random();
        req_s        reqs[$];
        logic [31:0] exp_q[$];
        bit          exp_err;
        logic [32:0] m;
        do_reset();
        exp_err = 1'b0;
        for (int n = 0; n < 48; n++) begin
            reqs.push_back(rand_req());
            m = ref_encode(reqs[n]);
            if (m[32]) exp_q.push_back(m[31:0]);
            else exp_err = 1'b1;
        end
        fork
            begin
                bit ok;
                foreach (reqs[k]) begin
                    repeat ($urandom_range(0, 2)) step();
                    send(reqs[k], ok);
                    vectors++;
                    if (!ok) begin miscompares++; $display("FAIL rand_send_timeout idx=%0d got 0 want 1", k); end
                end
            end
            begin
                bit ok;
                foreach (exp_q[k]) begin
                    wait_we(ok);
                    repeat ($urandom_range(0, 2)) step();
                    vectors++;
                    if (!ok || bus.imem_wdata !== exp_q[k] || bus.imem_addr !== 32'(k * 4)) begin
                        miscompares++;
                        $display("FAIL rand_write idx=%0d got we=%b addr=%h data=%h want addr=%h data=%h",
                                 k, bus.imem_we, bus.imem_addr, bus.imem_wdata, 32'(k * 4), exp_q[k]);
                    end
                    pulse_ack();
                end
            end
        join
        repeat (3) step();
        vectors++;
        if (err !== exp_err || bus.imem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_final got err=%b we=%b want err=%b we=0", err, bus.imem_we, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        req_s        reqs[DEPTH+1];
        logic [32:0] m;
        bit          ok;
        do_reset();
        foreach (reqs[k]) begin
            reqs[k] = rand_req();
            reqs[k].mode = 2'd1;
            reqs[k].opc = OP_LDR;
        end
        for (int k = 0; k < DEPTH; k++) begin
            send(reqs[k], ok);
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL b2b_fill idx=%0d got 0 want 1", k); end
        end
        bus.req_valid = 1'b1;
        repeat (3) step();
        m = ref_encode(reqs[0]);
        vectors++;
        if (bus.req_ready !== 1'b0 || bus.imem_wdata !== m[31:0]) begin
            miscompares++;
            $display("FAIL b2b_full got ready=%b data=%h want ready=0 data=%h", bus.req_ready, bus.imem_wdata, m[31:0]);
        end
        fork
            begin
                bit sok;
                send(reqs[DEPTH], sok);
                vectors++;
                if (!sok) begin miscompares++; $display("FAIL b2b_last_send got 0 want 1"); end
            end
            begin
                bit wok;
                for (int k = 0; k <= DEPTH; k++) begin
                    logic [32:0] e;
                    e = ref_encode(reqs[k]);
                    wait_we(wok);
                    vectors++;
                    if (!wok || bus.imem_wdata !== e[31:0] || bus.imem_addr !== 32'(k * 4)) begin
                        miscompares++;
                        $display("FAIL b2b_write idx=%0d got addr=%h data=%h want addr=%h data=%h",
                                 k, bus.imem_addr, bus.imem_wdata, 32'(k * 4), e[31:0]);
                    end
                    pulse_ack();
                end
            end
        join
    endtask

    task automatic test_seal();
        req_s        reqs[2];
        logic [32:0] e;
        bit          ok;
        do_reset();
        foreach (reqs[k]) begin
            reqs[k] = rand_req();
            reqs[k].mode = 2'd2;
            reqs[k].opc = OP_BL;
            send(reqs[k], ok);
        end
        seal = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = (k < 2) ? ref_encode(reqs[k]) : {1'b1, 32'hEAFFFFFE};
            wait_we(ok);
            vectors++;
            if (!ok || bus.imem_wdata !== e[31:0] || bus.imem_addr !== 32'(k * 4)) begin
                miscompares++;
                $display("FAIL seal_write idx=%0d got addr=%h data=%h want addr=%h data=%h",
                         k, bus.imem_addr, bus.imem_wdata, 32'(k * 4), e[31:0]);
            end
            pulse_ack();
        end
        seal = 1'b0;
        pulse_ack();
        step();
        vectors++;
        if (done !== 1'b1 || bus.req_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL seal_done got done=%b ready=%b we=%b want 1/0/0", done, bus.req_ready, bus.imem_we);
        end
    endtask

    task automatic test_rst_mid_write();
        req_s r;
        bit   ok;
        bit   saw_we;
        do_reset();
        r = rand_req();
        r.mode = 2'b11;
        send(r, ok);
        for (int k = 0; k < 3; k++) begin
            r = rand_req();
            r.mode = 2'd1;
            r.opc = OP_LDR;
            send(r, ok);
        end
        wait_we(ok);
        pulse_ack();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (bus.imem_we !== 1'b0 || bus.imem_addr !== 32'h0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid got we=%b addr=%h err=%b want 0/0/0", bus.imem_we, bus.imem_addr, err);
        end
        saw_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.imem_we) saw_we = 1'b1;
            step();
        end
        vectors++;
        if (saw_we) begin miscompares++; $display("FAIL rst_fifo_empty got we_seen=1 want 0"); end
    endtask

    initial begin
        req_s r;
        bus.req_valid = 1'b0;
        bus.imem_ack = 1'b0;
        bus.req_cond = '0; bus.req_mode = '0; bus.req_opCode = '0; bus.req_S = 1'b0;
        bus.req_I = 1'b0; bus.req_rn = '0; bus.req_rd = '0; bus.req_op2 = '0; bus.req_imm24 = '0;
        test_reset();
        r = '{cond: 4'hE, mode: 2'd0, opc: OP_ADD, s: 1'b0, i: 1'b1, rn: 4'd1, rd: 4'd2,
              op2: 12'h005, imm24: 24'h0};
        test_single("add", r, 32'hE2812005);
        r = '{cond: 4'hE, mode: 2'd0, opc: OP_CMP, s: 1'b0, i: 1'b0, rn: 4'd3, rd: 4'd0,
              op2: 12'h004, imm24: 24'h0};
        test_single("cmp", r, 32'hE1530004);
        test_illegal();
        test_random();
        test_back_to_back();
        test_seal();
        test_rst_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
